// File: rtl/bitplane_to_raster.sv
// Bitplane-to-raster pixel decode: aligns command/mode with RAM latency and extracts 8/4/2/1 bpp pixels.
// Optional build macro BP2R_PALETTE_OFFSET_EN: fg high bits select the palette bank in 4/2 bpp modes.
module bitplane_to_raster #(
  parameter int RAM_READ_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pc_ena_in,
  input  logic [7:0]  cmd_in,
  input  logic [23:0] bp_2_rast_cmd,
  input  logic [7:0]  ram_byte,
  output logic [7:0]  pixel_out,
  output logic        pixel_ena
);

  logic [7:0]  cmd_dly_q  [RAM_READ_CYCLES];
  logic [23:0] mode_dly_q [RAM_READ_CYCLES];
  logic [23:0] mode_q;
  logic [7:0]  pixel_q, pixel_d;
  logic        ena_q, ena_d;
  logic [23:0] mode_d;
  logic [7:0]  d_cmd;
  logic [23:0] d_mode;
  logic        strobe;

  function automatic logic [7:0] extract_pixel(input logic [7:0]  b,
                                               input logic [7:0]  cmd,
                                               input logic [23:0] mode);
    logic [2:0] sub;
    logic [7:0] fg, bg;
    logic [3:0] nib;
    logic [1:0] pair;
    sub  = cmd[2:0];
    bg   = mode[15:8];
    fg   = mode[23:16];
    nib  = sub[2] ? b[3:0] : b[7:4];
    case (sub[2:1])
      2'd0:    pair = b[7:6];
      2'd1:    pair = b[5:4];
      2'd2:    pair = b[3:2];
      default: pair = b[1:0];
    endcase
    case (mode[1:0])
      2'd0: extract_pixel = b;
`ifdef BP2R_PALETTE_OFFSET_EN
      2'd1: extract_pixel = {fg[7:4], nib};
      2'd2: extract_pixel = {fg[7:2], pair};
`else
      2'd1: extract_pixel = {4'h0, nib};
      2'd2: extract_pixel = {6'h00, pair};
`endif
      default: extract_pixel = b[3'd7 - sub] ? fg : bg;
    endcase
  endfunction

  // Stage p0..pN-1: command/mode delay line matching RAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_READ_CYCLES; i++) begin
        cmd_dly_q[i]  <= 8'h00;
        mode_dly_q[i] <= 24'h000000;
      end
    end else begin
      cmd_dly_q[0]  <= cmd_in;
      mode_dly_q[0] <= bp_2_rast_cmd;
      for (int i = 1; i < RAM_READ_CYCLES; i++) begin
        cmd_dly_q[i]  <= cmd_dly_q[i-1];
        mode_dly_q[i] <= mode_dly_q[i-1];
      end
    end
  end

  assign d_cmd  = cmd_dly_q[RAM_READ_CYCLES-1];
  assign d_mode = mode_dly_q[RAM_READ_CYCLES-1];
  assign strobe = (pc_ena_in == 4'(RAM_READ_CYCLES));

  // Mode only reloads outside the window, so a line never changes format mid-way
  always_comb begin
    mode_d  = mode_q;
    pixel_d = pixel_q;
    ena_d   = ena_q;
    if (strobe) begin
      ena_d   = d_cmd[7];
      pixel_d = d_cmd[7] ? extract_pixel(ram_byte, d_cmd, mode_q) : 8'h00;
      if (!d_cmd[7]) mode_d = d_mode;
    end
  end

  // Stage pN: output and mode registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= 24'h000000;
      pixel_q <= 8'h00;
      ena_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pixel_q <= pixel_d;
      ena_q   <= ena_d;
    end
  end

  assign pixel_out = pixel_q;
  assign pixel_ena = ena_q;

endmodule

// File: tb/tb_bitplane_to_raster.sv
// Directed bench for bitplane_to_raster: latency, bpp extraction, mode lock, blanking and async reset.
module tb_bitplane_to_raster;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  pc_ena_in = 4'd0;
  logic [7:0]  cmd_in = 8'h00;
  logic [23:0] bp_cmd = 24'h000000;
  logic [7:0]  ram_byte = 8'h00;
  logic [7:0]  pixel_out;
  logic        pixel_ena;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  prev_px = 8'h00;
  logic        prev_en = 1'b0;
  logic [7:0]  sweep_exp [8];

  bitplane_to_raster #(.RAM_READ_CYCLES(3)) dut (
    .clk(clk),
    .reset(rst),
    .pc_ena_in(pc_ena_in),
    .cmd_in(cmd_in),
    .bp_2_rast_cmd(bp_cmd),
    .ram_byte(ram_byte),
    .pixel_out(pixel_out),
    .pixel_ena(pixel_ena)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One full pixel period; checks hold-before-strobe, update-after-strobe and hold-to-end.
  task automatic run_period(input string tag, input logic [7:0] cmd, input logic [23:0] bp,
                            input logic [7:0] ram, input logic [7:0] exp_px, input logic exp_en);
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      if (p == 3) begin
        check_val({tag, "_pre_px"}, 32'(pixel_out), 32'(prev_px));
        check_val({tag, "_pre_en"}, 32'(pixel_ena), 32'(prev_en));
      end
      if (p == 4) begin
        check_val({tag, "_px"}, 32'(pixel_out), 32'(exp_px));
        check_val({tag, "_en"}, 32'(pixel_ena), 32'(exp_en));
      end
      if (p == 15) check_val({tag, "_hold_px"}, 32'(pixel_out), 32'(exp_px));
      pc_ena_in = 4'(p);
      cmd_in    = cmd;
      bp_cmd    = bp;
      ram_byte  = ram;
    end
    prev_px = exp_px;
    prev_en = exp_en;
  endtask

  initial begin
    sweep_exp[0] = 8'h3C; sweep_exp[1] = 8'h01; sweep_exp[2] = 8'h3C; sweep_exp[3] = 8'h01;
    sweep_exp[4] = 8'h01; sweep_exp[5] = 8'h01; sweep_exp[6] = 8'h01; sweep_exp[7] = 8'h01;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_px", 32'(pixel_out), 32'h00);
    check_val("rst_en", 32'(pixel_ena), 32'h0);
    rst = 1'b0;

    // 8bpp latency
    run_period("b8", 8'h80, 24'h000000, 8'hA5, 8'hA5, 1'b1);

    // 1bpp sweep
    run_period("ld1", 8'h00, 24'h3C0103, 8'hFF, 8'h00, 1'b0);
    for (int s = 0; s < 8; s++)
      run_period($sformatf("b1_s%0d", s), 8'h80 | 8'(s), 24'h3C0103, 8'hA0, sweep_exp[s], 1'b1);

    // 4bpp
    run_period("ld4", 8'h00, 24'h700001, 8'hFF, 8'h00, 1'b0);
`ifdef BP2R_PALETTE_OFFSET_EN
    run_period("b4_s4", 8'h84, 24'h700001, 8'h9E, 8'h7E, 1'b1);
    run_period("b4_s0", 8'h80, 24'h700001, 8'h9E, 8'h79, 1'b1);
`else
    run_period("b4_s4", 8'h84, 24'h700001, 8'h9E, 8'h0E, 1'b1);
    run_period("b4_s0", 8'h80, 24'h700001, 8'h9E, 8'h09, 1'b1);
`endif

    // 2bpp, ram 9C = pairs 10,01,11,00
    run_period("ld2", 8'h00, 24'hFC0002, 8'hFF, 8'h00, 1'b0);
`ifdef BP2R_PALETTE_OFFSET_EN
    run_period("b2_s0", 8'h80, 24'hFC0002, 8'h9C, 8'hFE, 1'b1);
    run_period("b2_s2", 8'h82, 24'hFC0002, 8'h9C, 8'hFD, 1'b1);
    run_period("b2_s6", 8'h86, 24'hFC0002, 8'h9C, 8'hFC, 1'b1);
`else
    run_period("b2_s0", 8'h80, 24'hFC0002, 8'h9C, 8'h02, 1'b1);
    run_period("b2_s2", 8'h82, 24'hFC0002, 8'h9C, 8'h01, 1'b1);
    run_period("b2_s6", 8'h86, 24'hFC0002, 8'h9C, 8'h00, 1'b1);
`endif

    // Mode lock: 1bpp request ignored while window enabled
    run_period("lk_ld0", 8'h00, 24'h3C0100, 8'hFF, 8'h00, 1'b0);
    run_period("lk_a",   8'h80, 24'h3C0100, 8'hA0, 8'hA0, 1'b1);
    run_period("lk_b",   8'h80, 24'h3C0103, 8'hA0, 8'hA0, 1'b1);
    run_period("lk_c",   8'h81, 24'h3C0103, 8'hA0, 8'hA0, 1'b1);
    run_period("lk_ld3", 8'h00, 24'h3C0103, 8'hFF, 8'h00, 1'b0);
    run_period("lk_d",   8'h82, 24'h3C0103, 8'hA0, 8'h3C, 1'b1);

    // Blanking in every mode
    for (int m = 0; m < 4; m++)
      run_period($sformatf("blank_m%0d", m), 8'h07, 24'h3C0100 | 24'(m), 8'hFF, 8'h00, 1'b0);

    // Async reset mid-period with window active (mode_reg holds 1bpp beforehand)
    run_period("pr_ld3", 8'h00, 24'h3C0103, 8'hFF, 8'h00, 1'b0);
    run_period("pr_a",   8'h80, 24'h3C0103, 8'h80, 8'h3C, 1'b1);
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      pc_ena_in = 4'(p);
      cmd_in    = 8'h80;
      bp_cmd    = 24'h3C0103;
      ram_byte  = 8'h80;
    end
    #2;
    check_val("pre_rst_px", 32'(pixel_out), 32'h3C);
    rst = 1'b1;
    #1;
    check_val("mid_rst_px", 32'(pixel_out), 32'h00);
    check_val("mid_rst_en", 32'(pixel_ena), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev_px = 8'h00;
    prev_en = 1'b0;
    // mode_reg cleared to 8bpp: raw byte comes through despite 1bpp request
    run_period("post_rst", 8'h80, 24'h3C0103, 8'hA5, 8'hA5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
